// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer and sample-value source for uart_rx_os.
// UART_RX_MAJORITY_EN selects 2-of-3 majority over the last three ticks.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef UART_RX_MAJORITY_EN
    input  logic sample_tick,
`endif
    input  logic rxd,
    output logic rxd_s,
    output logic sample
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    assign rxd_s = sync2;

`ifdef UART_RX_MAJORITY_EN
    // hist[0] is rxd_s at the previous tick, hist[1] the tick before that
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist <= 2'b11;
        end else if (sample_tick) begin
            hist <= {hist[0], sync2};
        end
    end

    assign sample = maj3(sync2, hist[0], hist[1]);
`else
    assign sample = sync2;
`endif

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frame FSM, counters, shift register and a
// valid/ready output register with overrun detection. Optional: UART_RX_MAJORITY_EN.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic                 rx_busy,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_ovr
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic rxd_s;
    logic sample;

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .rst        (rst),
`ifdef UART_RX_MAJORITY_EN
        .sample_tick(sample_tick),
`endif
        .rxd        (rxd),
        .rxd_s      (rxd_s),
        .sample     (sample)
    );

    rx_state_e            state_q, state_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 fperr_q, fperr_d;
    logic                 fferr_q, fferr_d;
    logic                 commit_q, commit_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            os_q     <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            fperr_q  <= 1'b0;
            fferr_q  <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            os_q     <= os_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            fperr_q  <= fperr_d;
            fferr_q  <= fferr_d;
            commit_q <= commit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        os_d     = os_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fperr_d  = fperr_q;
        fferr_d  = fferr_q;
        commit_d = 1'b0;
        if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d = START;
                        os_d    = '0;
                    end
                end
                START: begin
                    if (os_q == OS_HALF) begin
                        os_d = '0;
                        if (sample) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bit_d   = '0;
                            fperr_d = 1'b0;
                            fferr_d = 1'b0;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
                DATA: begin
                    if (os_q == OS_LAST) begin
                        os_d    = '0;
                        shift_d = {sample, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (os_q == OS_LAST) begin
                        os_d    = '0;
                        fperr_d = ((^shift_q) ^ sample) != (PARITY_MODE == PAR_ODD);
                        state_d = STOP;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
                STOP: begin
                    if (os_q == OS_LAST) begin
                        os_d = '0;
                        if (!sample) begin
                            fferr_d = 1'b1;
                        end
                        // Leave at mid-stop so a back-to-back start edge is not missed
                        if (bit_q == STOP_LAST) begin
                            state_d  = IDLE;
                            bit_d    = '0;
                            commit_d = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output handshake: a frame transfers on any edge where rx_valid && rx_ready;
    // rx_ready may be high while rx_valid is low, and a commit into a full,
    // unaccepted register is dropped with a one-cycle rx_ovr pulse.
    logic load;
    assign load = commit_q && (!rx_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            rx_busy <= (state_d != IDLE);
            rx_ovr  <= commit_q && rx_valid && !rx_ready;
            if (load) begin
                rx_valid <= 1'b1;
                rx_data  <= shift_q;
                rx_perr  <= fperr_q;
                rx_ferr  <= fferr_q;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1, 8E1 and 8N2 receivers share one serial line.
module tb_uart_rx_os;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic rxd = 1'b1;
    logic tick = 1'b1;
    logic ready_a = 1'b1;
    logic ready_bc = 1'b1;

    logic       busy_a, valid_a, perr_a, ferr_a, ovr_a;
    logic [7:0] data_a;
    logic       busy_b, valid_b, perr_b, ferr_b, ovr_b;
    logic [7:0] data_b;
    logic       busy_c, valid_c, perr_c, ferr_c, ovr_c;
    logic [7:0] data_c;

    uart_rx_os dut_a (
        .clk(clk), .rst(rst), .sample_tick(tick), .rxd(rxd),
        .rx_busy(busy_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a), .rx_ovr(ovr_a)
    );

    uart_rx_os #(.PARITY_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .sample_tick(tick), .rxd(rxd),
        .rx_busy(busy_b), .rx_valid(valid_b), .rx_ready(ready_bc),
        .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b), .rx_ovr(ovr_b)
    );

    uart_rx_os #(.STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .sample_tick(tick), .rxd(rxd),
        .rx_busy(busy_c), .rx_valid(valid_c), .rx_ready(ready_bc),
        .rx_data(data_c), .rx_perr(perr_c), .rx_ferr(ferr_c), .rx_ovr(ovr_c)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Monitor: count valid cycles and overrun pulses, capture accepted frames
    int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0, ocnt_a = 0;
    logic [7:0] last_data_a, last_data_b, last_data_c;
    logic last_perr_a, last_ferr_a, last_perr_b, last_ferr_c;

    always @(negedge clk) begin
        if (valid_a) begin
            vcnt_a++;
            last_data_a = data_a;
            last_perr_a = perr_a;
            last_ferr_a = ferr_a;
        end
        if (valid_b) begin
            vcnt_b++;
            last_data_b = data_b;
            last_perr_b = perr_b;
        end
        if (valid_c) begin
            vcnt_c++;
            last_data_c = data_c;
            last_ferr_c = ferr_c;
        end
        if (ovr_a) ocnt_a++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive n line bits LSB first, one bit period (16 ticks) each
    task automatic send_bits(input int n, input logic [15:0] bits);
        for (int i = 0; i < n; i++) begin
            rxd = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_valid"}, 32'(valid_a), 32'h0);
        check({tag, "_data"},  32'(data_a),  32'h0);
        check({tag, "_perr"},  32'(perr_a),  32'h0);
        check({tag, "_ferr"},  32'(ferr_a),  32'h0);
        check({tag, "_ovr"},   32'(ovr_a),   32'h0);
        check({tag, "_busy"},  32'(busy_a),  32'h0);
    endtask

    int v0, v1, v2, o0;

    initial begin
        // reset state
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_a_zero("rst");
        rst = 1'b1;
        idle(20);

        // 8N1 0xA5
        v0 = vcnt_a;
        send_bits(10, {6'h0, 1'b1, 8'hA5, 1'b0});
        idle(2);
        check("a5_vcycles", 32'(vcnt_a - v0), 32'd1);
        check("a5_data", 32'(last_data_a), 32'hA5);
        check("a5_perr", 32'(last_perr_a), 32'h0);
        check("a5_ferr", 32'(last_ferr_a), 32'h0);
        check("a5_busy", 32'(busy_a), 32'h0);
        idle(300);

        // even parity, data 0x03: parity bit 1 is wrong, parity bit 0 is right
        v0 = vcnt_b;
        send_bits(11, {5'h0, 1'b1, 1'b1, 8'h03, 1'b0});
        idle(2);
        check("par1_vcycles", 32'(vcnt_b - v0), 32'd1);
        check("par1_data", 32'(last_data_b), 32'h03);
        check("par1_perr", 32'(last_perr_b), 32'h1);
        idle(300);
        send_bits(11, {5'h0, 1'b1, 1'b0, 8'h03, 1'b0});
        idle(2);
        check("par0_data", 32'(last_data_b), 32'h03);
        check("par0_perr", 32'(last_perr_b), 32'h0);
        idle(300);

        // stop bit low on 8N1
        send_bits(10, {6'h0, 1'b0, 8'h3C, 1'b0});
        idle(2);
        check("stop_lo_data", 32'(last_data_a), 32'h3C);
        check("stop_lo_ferr", 32'(last_ferr_a), 32'h1);
        idle(300);

        // 8N2: second stop low, then a clean frame
        send_bits(11, {5'h0, 1'b0, 1'b1, 8'h96, 1'b0});
        idle(2);
        check("stop2_lo_data", 32'(last_data_c), 32'h96);
        check("stop2_lo_ferr", 32'(last_ferr_c), 32'h1);
        idle(300);
        v0 = vcnt_c;
        send_bits(11, {5'h0, 1'b1, 1'b1, 8'h81, 1'b0});
        idle(2);
        check("stop2_ok_vcycles", 32'(vcnt_c - v0), 32'd1);
        check("stop2_ok_data", 32'(last_data_c), 32'h81);
        check("stop2_ok_ferr", 32'(last_ferr_c), 32'h0);
        idle(300);

        // 4-clk low glitch: false start, nothing delivered
        v0 = vcnt_a; v1 = vcnt_b; v2 = vcnt_c;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_hi", 32'(busy_a), 32'h1);
        idle(40);
        check("glitch_busy_lo", 32'(busy_a), 32'h0);
        check("glitch_va", 32'(vcnt_a - v0), 32'd0);
        check("glitch_vb", 32'(vcnt_b - v1), 32'd0);
        check("glitch_vc", 32'(vcnt_c - v2), 32'd0);
        check("glitch_ovr", 32'(ocnt_a), 32'd0);

        // overrun: consumer stalled, two back-to-back frames
        ready_a = 1'b0;
        o0 = ocnt_a;
        send_bits(10, {6'h0, 1'b1, 8'h11, 1'b0});
        send_bits(10, {6'h0, 1'b1, 8'h22, 1'b0});
        idle(4);
        check("ovr_valid", 32'(valid_a), 32'h1);
        check("ovr_data", 32'(data_a), 32'h11);
        check("ovr_pulses", 32'(ocnt_a - o0), 32'd1);
        ready_a = 1'b1;
        repeat (2) @(negedge clk);
        check("ovr_drain_valid", 32'(valid_a), 32'h0);
        check("ovr_drain_data", 32'(data_a), 32'h11);
        idle(300);

        // reset in the middle of data bit 3 of 0xFF
        send_bits(4, 16'b1110);
        repeat (8) @(negedge clk);
        check("mid_busy", 32'(busy_a), 32'h1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_a_zero("midrst");
        rst = 1'b1;
        idle(300);
        v0 = vcnt_a;
        send_bits(10, {6'h0, 1'b1, 8'h5A, 1'b0});
        idle(2);
        check("post_rst_vcycles", 32'(vcnt_a - v0), 32'd1);
        check("post_rst_data", 32'(last_data_a), 32'h5A);
        check("post_rst_ferr", 32'(last_ferr_a), 32'h0);
        idle(50);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
